regfile_sb: RTL and testbench



---
 rtl/regfile_sb.sv | 110 +++++++++++
 tb/tb_regfile_sb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with a pending-write scoreboard.
//
// It holds NREGS registers of XLEN bits. It has NRD combinational read ports and
// one write port. A per-register pending bit is set when a producer issues, and it
// is cleared by the matching writeback or by a flush.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset. Reset clears the data
//                   array and the pending bits.
//   RAddr_RF      - packed read addresses; port i is bits [i*AW +: AW].
//   RD_RF         - packed read data; port i is bits [i*XLEN +: XLEN].
//   Busy_RF       - per read port: the addressed register awaits writeback.
//   WrEn_RF, WAddr_RF, WD_RF - writeback port.
//   Issue_RF, IssueAddr_RF   - mark a destination register as pending.
//   IssueBusy_RF  - the issue destination is already pending (WAW hazard, advisory).
//   Flush_RF      - clear all pending bits; register data is kept.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    RAddr_RF,
    output logic [NRD*XLEN-1:0]  RD_RF,
    output logic [NRD-1:0]       Busy_RF,
    input  logic                 WrEn_RF,
    input  logic [AW-1:0]        WAddr_RF,
    input  logic [XLEN-1:0]      WD_RF,
    input  logic                 Issue_RF,
    input  logic [AW-1:0]        IssueAddr_RF,
    output logic                 IssueBusy_RF,
    input  logic                 Flush_RF
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Register 0 is hardwired to zero when ZERO_REG is set.
    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // The write-port value is forwarded to any reader of the same address.
    function automatic logic is_fwd(input logic [AW-1:0] a, input logic we,
                                    input logic [AW-1:0] wa);
        return (BYPASS != 0) && we && (a == wa);
    endfunction

    // Next-state: the later scoreboard action wins (flush, then write-clear, then issue).
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (WrEn_RF && !is_zero(WAddr_RF)) begin
            mem_d[WAddr_RF] = WD_RF;
        end
        if (Flush_RF) begin
            pend_d = '0;
        end
        if (WrEn_RF) begin
            pend_d[WAddr_RF] = 1'b0;
        end
        if (Issue_RF && !is_zero(IssueAddr_RF)) begin
            pend_d[IssueAddr_RF] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    // Read ports. A forwarded value is never busy because the producer is writing it now.
    always_comb begin
        RD_RF   = '0;
        Busy_RF = '0;
        for (int i = 0; i < NRD; i++) begin
            if (is_zero(RAddr_RF[i*AW +: AW])) begin
                RD_RF[i*XLEN +: XLEN] = '0;
                Busy_RF[i]            = 1'b0;
            end else if (is_fwd(RAddr_RF[i*AW +: AW], WrEn_RF, WAddr_RF)) begin
                RD_RF[i*XLEN +: XLEN] = WD_RF;
                Busy_RF[i]            = 1'b0;
            end else begin
                RD_RF[i*XLEN +: XLEN] = mem_q[RAddr_RF[i*AW +: AW]];
                Busy_RF[i]            = pend_q[RAddr_RF[i*AW +: AW]];
            end
        end
    end

    always_comb begin
        IssueBusy_RF = pend_q[IssueAddr_RF]
                     && !is_zero(IssueAddr_RF)
                     && !is_fwd(IssueAddr_RF, WrEn_RF, WAddr_RF);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb. Instance A uses the default configuration (32x32, 2 read
// ports, zero register, bypass). Instance B uses 16x64 with 3 read ports, no zero
// register and no bypass. Expected records are queued when stimulus is driven.
// They are popped and compared at the falling edge.
module tb_regfile_sb;

    localparam int AWB = 4;
    localparam int XB  = 64;
    localparam int NB  = 16;
    localparam int RB  = 3;
    localparam int ZB  = 0;
    localparam int BB  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        rst_a, we_a, iss_a, fl_a, ib_a;
    logic [4:0]  wa_a, ia_a;
    logic [31:0] wd_a;
    logic [9:0]  ra_a;
    logic [63:0] rd_a;
    logic [1:0]  busy_a;

    // Instance B signals
    logic            rst_b, we_b, iss_b, fl_b, ib_b;
    logic [AWB-1:0]  wa_b, ia_b;
    logic [XB-1:0]   wd_b;
    logic [RB*AWB-1:0] ra_b;
    logic [RB*XB-1:0]  rd_b;
    logic [RB-1:0]     busy_b;

    regfile_sb dut_a (
        .clk(clk), .rst(rst_a), .RAddr_RF(ra_a), .RD_RF(rd_a), .Busy_RF(busy_a),
        .WrEn_RF(we_a), .WAddr_RF(wa_a), .WD_RF(wd_a), .Issue_RF(iss_a),
        .IssueAddr_RF(ia_a), .IssueBusy_RF(ib_a), .Flush_RF(fl_a)
    );

    regfile_sb #(.XLEN(XB), .NREGS(NB), .NRD(RB), .ZERO_REG(ZB), .BYPASS(BB)) dut_b (
        .clk(clk), .rst(rst_b), .RAddr_RF(ra_b), .RD_RF(rd_b), .Busy_RF(busy_b),
        .WrEn_RF(we_b), .WAddr_RF(wa_b), .WD_RF(wd_b), .Issue_RF(iss_b),
        .IssueAddr_RF(ia_b), .IssueBusy_RF(ib_b), .Flush_RF(fl_b)
    );

    typedef struct {
        string        tag;
        logic [191:0] rd;
        logic [2:0]   busy;
        logic         ib;
    } exp_t;

    typedef struct {
        bit          chk;
        bit          rst;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          iss;
        logic [4:0]  ia;
        bit          fl;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        bit          eib;
    } vec_t;

    exp_t sbq[$];
    vec_t va[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state for instance B
    logic [XB-1:0] m_mem [NB];
    logic [NB-1:0] m_pend;
    logic [AWB-1:0] m_a;
    logic m_z, m_f;
    exp_t e;

    function automatic vec_t mk(bit chk, bit rst, bit we, int wa, logic [31:0] wd,
                                bit iss, int ia, bit fl, int r0, int r1,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb, bit eib);
        vec_t v;
        v.chk = chk; v.rst = rst; v.we = we; v.wa = 5'(wa); v.wd = wd;
        v.iss = iss; v.ia = 5'(ia); v.fl = fl; v.r0 = 5'(r0); v.r1 = 5'(r1);
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.eib = eib;
        return v;
    endfunction

    task automatic check_pop(input logic [191:0] rd, input logic [2:0] busy, input logic ib);
        exp_t x;
        n_tests++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: no expected record queued");
            return;
        end
        x = sbq.pop_front();
        if (rd !== x.rd) begin
            n_fail++;
            $display("FAIL %s RD_RF got=%h want=%h", x.tag, rd, x.rd);
        end
        n_tests++;
        if (busy !== x.busy) begin
            n_fail++;
            $display("FAIL %s Busy_RF got=%b want=%b", x.tag, busy, x.busy);
        end
        n_tests++;
        if (ib !== x.ib) begin
            n_fail++;
            $display("FAIL %s IssueBusy_RF got=%b want=%b", x.tag, ib, x.ib);
        end
    endtask

    task automatic drive_b(bit rst, bit we, int wa, logic [63:0] wd, bit iss, int ia,
                           bit fl, int r0, int r1, int r2);
        rst_b = rst; we_b = we; wa_b = AWB'(wa); wd_b = wd; iss_b = iss;
        ia_b = AWB'(ia); fl_b = fl;
        ra_b = {AWB'(r2), AWB'(r1), AWB'(r0)};
    endtask

    task automatic hand_b(string tag, bit we, int wa, logic [63:0] wd, bit iss, int ia,
                          int r0, int r1, int r2, logic [63:0] e0, logic [63:0] e1,
                          logic [63:0] e2, logic [2:0] eb, bit eib);
        @(posedge clk); #1;
        drive_b(1'b0, we, wa, wd, iss, ia, 1'b0, r0, r1, r2);
        sbq.push_back('{tag: tag, rd: {e2, e1, e0}, busy: eb, ib: eib});
        @(negedge clk);
        check_pop(rd_b, busy_b, ib_b);
    endtask

    initial begin
        rst_a = 1'b1; we_a = 1'b0; iss_a = 1'b0; fl_a = 1'b0;
        wa_a = '0; ia_a = '0; wd_a = '0; ra_a = '0;
        drive_b(1'b1, 1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 0, 0, 0);

        //        chk rst we wa wd            iss ia fl r0 r1  e0            e1            eb     eib
        va.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0));
        va.push_back(mk(0, 1, 1, 5, 32'h1,        1, 5, 0, 1, 2, 32'h0,        32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 5, 0, 5, 5, 32'h0,        32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 1, 0, 32'h12345678, 1, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 1, 7, 32'h11111111, 0, 0, 0, 7, 7, 32'h11111111, 32'h11111111, 2'b00, 0));
        va.push_back(mk(1, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 7, 32'h0,        32'hA5A5A5A5, 2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        1, 3, 0, 3, 3, 32'h0,        32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 3, 0, 3, 3, 32'h0,        32'h0,        2'b11, 1));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 3, 0, 3, 3, 32'h0,        32'h0,        2'b11, 1));
        va.push_back(mk(1, 0, 1, 3, 32'h11,       0, 3, 0, 3, 3, 32'h11,       32'h11,       2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 3, 0, 3, 3, 32'h11,       32'h11,       2'b00, 0));
        va.push_back(mk(1, 0, 1, 9, 32'h99,       1, 9, 0, 9, 0, 32'h99,       32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 9, 0, 9, 9, 32'h99,       32'h99,       2'b11, 1));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        1, 2, 0, 0, 0, 32'h0,        32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        1, 6, 0, 2, 6, 32'h0,        32'h0,        2'b01, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        1, 4, 1, 2, 6, 32'h0,        32'h0,        2'b11, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 4, 0, 2, 6, 32'h0,        32'h0,        2'b00, 1));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 9, 0, 4, 9, 32'h0,        32'h99,       2'b01, 0));
        va.push_back(mk(1, 0, 1, 4, 32'h44,       0, 4, 0, 4, 1, 32'h44,       32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 4, 0, 4, 4, 32'h44,       32'h44,       2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        1, 8, 0, 4, 4, 32'h44,       32'h44,       2'b00, 0));
        va.push_back(mk(0, 1, 1, 4, 32'h77,       1, 4, 0, 1, 1, 32'h0,        32'h0,        2'b00, 0));
        va.push_back(mk(1, 0, 0, 0, 32'h0,        0, 8, 0, 4, 8, 32'h0,        32'h0,        2'b00, 0));

        for (int k = 0; k < va.size(); k++) begin
            @(posedge clk); #1;
            rst_a = va[k].rst; we_a = va[k].we; wa_a = va[k].wa; wd_a = va[k].wd;
            iss_a = va[k].iss; ia_a = va[k].ia; fl_a = va[k].fl;
            ra_a  = {va[k].r1, va[k].r0};
            if (va[k].chk)
                sbq.push_back('{tag: $sformatf("A%0d", k), rd: {128'b0, va[k].e1, va[k].e0},
                                busy: {1'b0, va[k].eb}, ib: va[k].eib});
            @(negedge clk);
            if (va[k].chk) check_pop({128'b0, rd_a}, {1'b0, busy_a}, ib_a);
        end

        // Instance B hand sequences: no zero register, no bypass.
        @(posedge clk); #1;
        drive_b(1'b1, 1'b0, 0, 64'h0, 1'b0, 0, 1'b0, 0, 0, 0);
        hand_b("B_x0_write", 1, 0, 64'h12345678, 1, 0, 0, 0, 0,
               64'h0, 64'h0, 64'h0, 3'b000, 0);
        hand_b("B_x0_read", 0, 0, 64'h0, 0, 0, 0, 0, 0,
               64'h12345678, 64'h12345678, 64'h12345678, 3'b111, 1);
        hand_b("B_nobyp_old", 1, 7, 64'hA5A5A5A5, 0, 0, 7, 7, 0,
               64'h0, 64'h0, 64'h12345678, 3'b100, 1);
        hand_b("B_nobyp_new", 0, 0, 64'h0, 1, 3, 7, 3, 3,
               64'hA5A5A5A5, 64'h0, 64'h0, 3'b000, 0);
        hand_b("B_issue_busy", 0, 0, 64'h0, 0, 3, 3, 3, 3,
               64'h0, 64'h0, 64'h0, 3'b111, 1);
        hand_b("B_write_cycle", 1, 3, 64'h11, 0, 3, 3, 3, 3,
               64'h0, 64'h0, 64'h0, 3'b111, 1);
        hand_b("B_after_write", 0, 0, 64'h0, 0, 3, 3, 3, 3,
               64'h11, 64'h11, 64'h11, 3'b000, 0);

        // Instance B random sweep against the reference state.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk); #1;
            rst_b = (cyc == 0) || ($urandom_range(0, 499) == 0);
            we_b  = 1'($urandom_range(0, 1));
            wa_b  = AWB'($urandom_range(0, NB - 1));
            wd_b  = {$urandom, $urandom};
            iss_b = 1'($urandom_range(0, 1));
            ia_b  = AWB'($urandom_range(0, NB - 1));
            fl_b  = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < RB; i++) ra_b[i*AWB +: AWB] = AWB'($urandom_range(0, NB - 1));
            if (cyc != 0) begin
                e.tag  = $sformatf("B_sweep%0d", cyc);
                e.rd   = '0;
                e.busy = '0;
                for (int i = 0; i < RB; i++) begin
                    m_a = ra_b[i*AWB +: AWB];
                    m_z = (ZB != 0) && (m_a == 0);
                    m_f = (BB != 0) && we_b && (m_a == wa_b);
                    e.rd[i*XB +: XB] = m_z ? 64'h0 : (m_f ? wd_b : m_mem[m_a]);
                    e.busy[i] = m_pend[m_a] && !m_z && !m_f;
                end
                m_z  = (ZB != 0) && (ia_b == 0);
                m_f  = (BB != 0) && we_b && (ia_b == wa_b);
                e.ib = m_pend[ia_b] && !m_z && !m_f;
                sbq.push_back(e);
            end
            @(negedge clk);
            if (cyc != 0) check_pop(rd_b, busy_b, ib_b);
            if (rst_b) begin
                for (int r = 0; r < NB; r++) m_mem[r] = '0;
                m_pend = '0;
            end else begin
                if (we_b && !((ZB != 0) && (wa_b == 0))) m_mem[wa_b] = wd_b;
                if (fl_b) m_pend = '0;
                if (we_b) m_pend[wa_b] = 1'b0;
                if (iss_b && !((ZB != 0) && (ia_b == 0))) m_pend[ia_b] = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
